// File: rtl/alu_operand_stage.sv
// Registered ALU issue stage: decodes F, selects B, and buffers ops in a main + skid register pair.
// Optional statistics counters are enabled with the ALU_OPSTAGE_STATS_EN macro.
module alu_operand_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned IMM_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic [IMM_W-1:0] imm,
  input  logic             alu_src,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic [2:0]       f_out,
  output logic             illegal
`ifdef ALU_OPSTAGE_STATS_EN
  ,
  output logic [31:0]      stat_issued,
  output logic [31:0]      stat_illegal
`endif
);

  logic             main_valid_q, main_valid_d;
  logic [WIDTH-1:0] main_a_q, main_a_d, main_b_q, main_b_d;
  logic [2:0]       main_f_q, main_f_d;
  logic             main_ill_q, main_ill_d;
  logic             skid_full_q, skid_full_d;
  logic [WIDTH-1:0] skid_a_q, skid_a_d, skid_b_q, skid_b_d;
  logic [2:0]       skid_f_q, skid_f_d;
  logic             skid_ill_q, skid_ill_d;

  logic [2:0]       dec_f;
  logic             dec_ill;
  logic [WIDTH-1:0] ext_imm;
  logic [WIDTH-1:0] dec_b;
  logic             in_xfer;
  logic             out_xfer;

  always_comb begin
    dec_f   = 3'b010;
    dec_ill = 1'b0;
    unique case (alu_op)
      2'b00: dec_f = 3'b010;
      2'b01: dec_f = 3'b110;
      2'b11: dec_f = 3'b001;
      2'b10: begin
        case (funct)
          6'b100000: dec_f = 3'b010;
          6'b100010: dec_f = 3'b110;
          6'b100100: dec_f = 3'b000;
          6'b100101: dec_f = 3'b001;
          6'b101010: dec_f = 3'b111;
          default:   dec_ill = 1'b1;
        endcase
      end
      default: dec_f = 3'b010;
    endcase
    // ORI-class ops take a zero-extended immediate; everything else sign-extends.
    ext_imm = (alu_op == 2'b11) ? {{(WIDTH - IMM_W){1'b0}}, imm}
                                : {{(WIDTH - IMM_W){imm[IMM_W-1]}}, imm};
    dec_b   = alu_src ? ext_imm : rt_data;
  end

  assign in_xfer  = in_valid && !skid_full_q;
  assign out_xfer = main_valid_q && out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    main_a_d     = main_a_q;
    main_b_d     = main_b_q;
    main_f_d     = main_f_q;
    main_ill_d   = main_ill_q;
    skid_full_d  = skid_full_q;
    skid_a_d     = skid_a_q;
    skid_b_d     = skid_b_q;
    skid_f_d     = skid_f_q;
    skid_ill_d   = skid_ill_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_full_d  = 1'b0;
    end else if (!main_valid_q || out_ready) begin
      if (skid_full_q) begin
        main_valid_d = 1'b1;
        main_a_d     = skid_a_q;
        main_b_d     = skid_b_q;
        main_f_d     = skid_f_q;
        main_ill_d   = skid_ill_q;
        skid_full_d  = 1'b0;
      end else if (in_xfer) begin
        main_valid_d = 1'b1;
        main_a_d     = rs_data;
        main_b_d     = dec_b;
        main_f_d     = dec_f;
        main_ill_d   = dec_ill;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (in_xfer) begin
      skid_full_d = 1'b1;
      skid_a_d    = rs_data;
      skid_b_d    = dec_b;
      skid_f_d    = dec_f;
      skid_ill_d  = dec_ill;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      main_valid_q <= 1'b0;
      main_a_q     <= '0;
      main_b_q     <= '0;
      main_f_q     <= 3'b010;
      main_ill_q   <= 1'b0;
      skid_full_q  <= 1'b0;
      skid_a_q     <= '0;
      skid_b_q     <= '0;
      skid_f_q     <= 3'b010;
      skid_ill_q   <= 1'b0;
    end else begin
      main_valid_q <= main_valid_d;
      main_a_q     <= main_a_d;
      main_b_q     <= main_b_d;
      main_f_q     <= main_f_d;
      main_ill_q   <= main_ill_d;
      skid_full_q  <= skid_full_d;
      skid_a_q     <= skid_a_d;
      skid_b_q     <= skid_b_d;
      skid_f_q     <= skid_f_d;
      skid_ill_q   <= skid_ill_d;
    end
  end

  assign in_ready  = !skid_full_q;
  assign out_valid = main_valid_q;
  assign a_out     = main_a_q;
  assign b_out     = main_b_q;
  assign f_out     = main_f_q;
  assign illegal   = main_ill_q;

`ifdef ALU_OPSTAGE_STATS_EN
  logic [31:0] stat_issued_q, stat_issued_d;
  logic [31:0] stat_illegal_q, stat_illegal_d;

  // A flush cancels the output transfer, so it is not counted either.
  always_comb begin
    stat_issued_d  = stat_issued_q;
    stat_illegal_d = stat_illegal_q;
    if (out_xfer && !flush) begin
      stat_issued_d = stat_issued_q + 32'd1;
      if (main_ill_q) stat_illegal_d = stat_illegal_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stat_issued_q  <= '0;
      stat_illegal_q <= '0;
    end else begin
      stat_issued_q  <= stat_issued_d;
      stat_illegal_q <= stat_illegal_d;
    end
  end

  assign stat_issued  = stat_issued_q;
  assign stat_illegal = stat_illegal_q;
`else
  logic unused_out_xfer;
  assign unused_out_xfer = out_xfer;
`endif

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: directed test-plan steps, then random traffic
// compared against a 2-deep FIFO reference model.
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] rs_data = '0;
  logic [31:0] rt_data = '0;
  logic [15:0] imm = '0;
  logic        alu_src = 1'b0;
  logic [1:0]  alu_op = 2'b00;
  logic [5:0]  funct = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] a_out;
  logic [31:0] b_out;
  logic [2:0]  f_out;
  logic        illegal;
`ifdef ALU_OPSTAGE_STATS_EN
  logic [31:0] stat_issued;
  logic [31:0] stat_illegal;
`endif

  always #5 clk = ~clk;

  alu_operand_stage #(.WIDTH(32), .IMM_W(16)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rs_data   (rs_data),
    .rt_data   (rt_data),
    .imm       (imm),
    .alu_src   (alu_src),
    .alu_op    (alu_op),
    .funct     (funct),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .a_out     (a_out),
    .b_out     (b_out),
    .f_out     (f_out),
    .illegal   (illegal)
`ifdef ALU_OPSTAGE_STATS_EN
    ,
    .stat_issued  (stat_issued),
    .stat_illegal (stat_illegal)
`endif
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  f;
    logic        ill;
  } op_t;

  op_t         q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_issued = '0;
  logic [31:0] m_illegal = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: the stage behaves as a 2-deep FIFO of decoded ops.
  function automatic op_t ref_op(input logic [1:0] op, input logic [5:0] fn, input logic src,
                                 input logic [31:0] rs, input logic [31:0] rt,
                                 input logic [15:0] im);
    op_t r;
    r.a   = rs;
    r.ill = 1'b0;
    r.f   = 3'b010;
    if (op == 2'b01) r.f = 3'b110;
    else if (op == 2'b11) r.f = 3'b001;
    else if (op == 2'b10) begin
      if (fn == 6'h20) r.f = 3'b010;
      else if (fn == 6'h22) r.f = 3'b110;
      else if (fn == 6'h24) r.f = 3'b000;
      else if (fn == 6'h25) r.f = 3'b001;
      else if (fn == 6'h2a) r.f = 3'b111;
      else r.ill = 1'b1;
    end
    if (!src) r.b = rt;
    else if (op == 2'b11) r.b = 32'(im);
    else r.b = 32'($signed(im));
    return r;
  endfunction

  task automatic compare_all();
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
    if (q.size() > 0) begin
      chk("a_out", a_out, q[0].a);
      chk("b_out", b_out, q[0].b);
      chk("f_out", 32'(f_out), 32'(q[0].f));
      chk("illegal", 32'(illegal), 32'(q[0].ill));
    end
`ifdef ALU_OPSTAGE_STATS_EN
    chk("stat_issued", stat_issued, m_issued);
    chk("stat_illegal", stat_illegal, m_illegal);
`endif
  endtask

  task automatic cyc(input logic iv, input logic ordy, input logic fl, input logic [1:0] op,
                     input logic [5:0] fn, input logic src, input logic [31:0] rs,
                     input logic [31:0] rt, input logic [15:0] im);
    bit pre_rdy;
    bit pre_vld;
    in_valid  = iv;
    out_ready = ordy;
    flush     = fl;
    alu_op    = op;
    funct     = fn;
    alu_src   = src;
    rs_data   = rs;
    rt_data   = rt;
    imm       = im;
    pre_rdy   = q.size() < 2;
    pre_vld   = q.size() > 0;
    @(posedge clk);
    if (!reset_n) begin
      q.delete();
      m_issued  = '0;
      m_illegal = '0;
    end else if (fl) begin
      q.delete();
    end else begin
      if (pre_vld && ordy) begin
        m_issued = m_issued + 32'd1;
        if (q[0].ill) m_illegal = m_illegal + 32'd1;
        void'(q.pop_front());
      end
      if (iv && pre_rdy) q.push_back(ref_op(op, fn, src, rs, rt, im));
    end
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input logic ordy);
    cyc(1'b0, ordy, 1'b0, 2'b00, 6'h00, 1'b0, 32'h0, 32'h0, 16'h0);
  endtask

  logic [5:0] legal_fn [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};

  initial begin
    reset_n = 1'b0;
    idle(1'b0);
    idle(1'b0);
    reset_n = 1'b1;
    chk("rst_a_out", a_out, 32'h0);
    chk("rst_b_out", b_out, 32'h0);
    chk("rst_f_out", 32'(f_out), 32'h2);
    chk("rst_illegal", 32'(illegal), 32'h0);
    idle(1'b1);
    chk("idle_in_ready", 32'(in_ready), 32'h1);

    // R-type subtract
    cyc(1'b1, 1'b1, 1'b0, 2'b10, 6'h22, 1'b0, 32'd5, 32'd3, 16'h0);
    chk("sub_a", a_out, 32'd5);
    chk("sub_b", b_out, 32'd3);
    chk("sub_f", 32'(f_out), 32'h6);
    chk("sub_ill", 32'(illegal), 32'h0);

    // Immediate extension
    cyc(1'b1, 1'b1, 1'b0, 2'b00, 6'h00, 1'b1, 32'd1, 32'd9, 16'hfffc);
    chk("sext_b", b_out, 32'hfffffffc);
    cyc(1'b1, 1'b1, 1'b0, 2'b11, 6'h00, 1'b1, 32'd1, 32'd9, 16'hfffc);
    chk("zext_b", b_out, 32'h0000fffc);
    chk("zext_f", 32'(f_out), 32'h1);
    idle(1'b1);

    // Backpressure: X then Y into a stalled stage
    cyc(1'b1, 1'b0, 1'b0, 2'b00, 6'h00, 1'b0, 32'h111, 32'h1, 16'h0);
    cyc(1'b1, 1'b0, 1'b0, 2'b01, 6'h00, 1'b0, 32'h222, 32'h2, 16'h0);
    chk("stall_hold_x", a_out, 32'h111);
    chk("stall_in_ready", 32'(in_ready), 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 2'b00, 6'h00, 1'b0, 32'h333, 32'h3, 16'h0);
    chk("stall_still_x", a_out, 32'h111);
    idle(1'b1);
    chk("drain_y", a_out, 32'h222);
    chk("drain_ready", 32'(in_ready), 32'h1);
    idle(1'b1);
    chk("drain_empty", 32'(out_valid), 32'h0);

    // Unrecognised funct
    cyc(1'b1, 1'b0, 1'b0, 2'b10, 6'h00, 1'b0, 32'h7, 32'h8, 16'h0);
    chk("ill_f", 32'(f_out), 32'h2);
    chk("ill_flag", 32'(illegal), 32'h1);
    idle(1'b1);
    idle(1'b1);

    // Flush with the skid full; the op presented with flush is dropped
    cyc(1'b1, 1'b0, 1'b0, 2'b00, 6'h00, 1'b0, 32'ha, 32'h1, 16'h0);
    cyc(1'b1, 1'b0, 1'b0, 2'b00, 6'h00, 1'b0, 32'hb, 32'h1, 16'h0);
    cyc(1'b1, 1'b1, 1'b1, 2'b00, 6'h00, 1'b0, 32'hc, 32'h1, 16'h0);
    chk("flush_valid", 32'(out_valid), 32'h0);
    chk("flush_ready", 32'(in_ready), 32'h1);
    cyc(1'b1, 1'b0, 1'b0, 2'b01, 6'h00, 1'b0, 32'hd, 32'h1, 16'h0);
    chk("post_flush_a", a_out, 32'hd);
    chk("post_flush_valid", 32'(out_valid), 32'h1);
    idle(1'b1);

    // Random traffic, with an occasional flush and one reset in the middle
    for (int i = 0; i < 600; i++) begin
      logic [1:0] op;
      logic [5:0] fn;
      op = 2'($urandom_range(0, 3));
      fn = ($urandom_range(0, 6) > 4) ? 6'($urandom) : legal_fn[$urandom_range(0, 4)];
      if (i == 300) reset_n = 1'b0;
      cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
          1'($urandom_range(0, 30) == 0), op, fn, 1'($urandom), $urandom, $urandom,
          16'($urandom));
      reset_n = 1'b1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
